// File: rtl/cla_pkg.sv
// Shared definitions for the carry-lookahead adder family.
//   SLICE_W  : bits handled by one lookahead slice
//   gp_t     : per-bit generate/propagate pair
//   gen_prop : builds the generate/propagate vectors for one slice
package cla_pkg;

    localparam int unsigned SLICE_W = 4;

    typedef struct packed {
        logic [SLICE_W-1:0] g;
        logic [SLICE_W-1:0] p;
    } gp_t;

    function automatic gp_t gen_prop(input logic [SLICE_W-1:0] a, input logic [SLICE_W-1:0] b);
        gp_t r;
        r.g = a & b;
        r.p = a ^ b;
        return r;
    endfunction

endpackage

// File: rtl/cla4.sv
// 4-bit carry-lookahead adder slice (purely combinational).
//   a, b   : slice operands
//   ci     : carry in
//   s      : slice sum
//   co     : carry out of bit 3
//   c_msb  : carry into bit 3, used by the caller for signed overflow
module cla4
    import cla_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               co,
    output logic               c_msb
);

    gp_t              gp;
    logic [SLICE_W:0] c;

    always_comb begin
        gp   = gen_prop(a, b);
        c[0] = ci;
        c[1] = gp.g[0] | (gp.p[0] & ci);
        c[2] = gp.g[1] | (gp.p[1] & gp.g[0]) | (gp.p[1] & gp.p[0] & ci);
        c[3] = gp.g[2] | (gp.p[2] & gp.g[1]) | (gp.p[2] & gp.p[1] & gp.g[0])
             | (gp.p[2] & gp.p[1] & gp.p[0] & ci);
        c[4] = gp.g[3] | (gp.p[3] & gp.g[2]) | (gp.p[3] & gp.p[2] & gp.g[1])
             | (gp.p[3] & gp.p[2] & gp.p[1] & gp.g[0])
             | (gp.p[3] & gp.p[2] & gp.p[1] & gp.p[0] & ci);
        s     = gp.p ^ c[SLICE_W-1:0];
        co    = c[4];
        c_msb = c[3];
    end

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined adder/subtractor built from WIDTH/4 cla4 slices, one slice per stage.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (a, b, ci, sub)
//   out_valid / out_ready: result handshake (s, co, ovf, zero)
//   sub=0: s = a + b + ci ; sub=1: s = a - b (ci ignored)
//   co: carry out of MSB, ovf: signed overflow, zero: s == 0
// Latency is NSLICE cycles; the whole pipe stalls when the output is held.
module cla_pipe_addsub
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf,
    output logic             zero
);

    localparam int NSLICE = WIDTH / SLICE_W;

    if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_width_check
        $error("cla_pipe_addsub: WIDTH must be a multiple of 4 and at least 4");
    end

    logic                           adv;
    logic                           accept;
    logic [WIDTH-1:0]               b_eff;
    logic                           c_in0;
    logic [NSLICE-1:0][SLICE_W-1:0] sl_a;
    logic [NSLICE-1:0][SLICE_W-1:0] sl_b;
    logic [NSLICE-1:0][SLICE_W-1:0] sl_s;
    logic [NSLICE-1:0]              sl_ci;
    logic [NSLICE-1:0]              sl_co;
    logic [NSLICE-1:0]              sl_cmsb;
    logic [WIDTH-1:0]               res;
    logic                           res_valid;
    logic                           unused_cmsb;

    // Single global advance: every stage moves together or holds together.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv && !rst;
    assign accept   = in_valid && in_ready;

    // Subtraction as a + ~b + 1; B is inverted once at entry and carried down the skew.
    assign b_eff = sub ? ~b : b;
    assign c_in0 = sub | ci;

    // Only the top slice's carry-into-bit-3 matters; the lower ones are sunk here.
    assign unused_cmsb = ^sl_cmsb;

    for (genvar k = 0; k < NSLICE; k++) begin : g_slice
        if (k == 0) begin : g_in
            assign sl_a[k]  = a[SLICE_W-1:0];
            assign sl_b[k]  = b_eff[SLICE_W-1:0];
            assign sl_ci[k] = c_in0;
        end else begin : g_in
            assign sl_a[k]  = g_reg[k-1].a_q[SLICE_W-1:0];
            assign sl_b[k]  = g_reg[k-1].b_q[SLICE_W-1:0];
            assign sl_ci[k] = g_reg[k-1].c_q;
        end

        cla4 u_cla4 (
            .a     (sl_a[k]),
            .b     (sl_b[k]),
            .ci    (sl_ci[k]),
            .s     (sl_s[k]),
            .co    (sl_co[k]),
            .c_msb (sl_cmsb[k])
        );
    end

    // Inter-stage registers: stage k keeps the finished low result slices (deskew)
    // and the not-yet-used high operand slices (skew), plus the slice carry.
    for (genvar k = 0; k < NSLICE - 1; k++) begin : g_reg
        localparam int unsigned RW = SLICE_W * (k + 1);
        localparam int unsigned OW = WIDTH - RW;

        logic          v_q;
        logic          c_q;
        logic [RW-1:0] s_q;
        logic [OW-1:0] a_q;
        logic [OW-1:0] b_q;
        logic          v_d;
        logic [RW-1:0] s_d;
        logic [OW-1:0] a_d;
        logic [OW-1:0] b_d;

        if (k == 0) begin : g_src
            assign v_d = accept;
            assign s_d = sl_s[k];
            assign a_d = a[WIDTH-1:SLICE_W];
            assign b_d = b_eff[WIDTH-1:SLICE_W];
        end else begin : g_src
            assign v_d = g_reg[k-1].v_q;
            assign s_d = {sl_s[k], g_reg[k-1].s_q};
            assign a_d = g_reg[k-1].a_q[OW+SLICE_W-1:SLICE_W];
            assign b_d = g_reg[k-1].b_q[OW+SLICE_W-1:SLICE_W];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
            end else if (adv) begin
                v_q <= v_d;
                c_q <= sl_co[k];
                s_q <= s_d;
                a_q <= a_d;
                b_q <= b_d;
            end
        end
    end

    if (NSLICE == 1) begin : g_tail
        assign res       = sl_s[0];
        assign res_valid = accept;
    end else begin : g_tail
        assign res       = {sl_s[NSLICE-1], g_reg[NSLICE-2].s_q};
        assign res_valid = g_reg[NSLICE-2].v_q;
    end

    // Output register; result fields only load on a valid beat so a bubble
    // does not disturb the last delivered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            s         <= '0;
            co        <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (adv) begin
            out_valid <= res_valid;
            if (res_valid) begin
                s    <= res;
                co   <= sl_co[NSLICE-1];
                ovf  <= sl_cmsb[NSLICE-1] ^ sl_co[NSLICE-1];
                zero <= (res == '0);
            end
        end
    end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
module tb_cla_pipe_addsub;

    typedef struct packed {
        logic [15:0] s;
        logic        co;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        ci = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] s;
    logic        co, ovf, zero;

    logic        in_valid4 = 1'b0;
    logic        in_ready4;
    logic [3:0]  a4 = '0;
    logic [3:0]  b4 = '0;
    logic        ci4 = 1'b0;
    logic        sub4 = 1'b0;
    logic        out_valid4;
    logic        out_ready4 = 1'b1;
    logic [3:0]  s4;
    logic        co4, ovf4, zero4;

    int checks = 0;
    int errors = 0;
    int emitted = 0;
    bit saw_stall = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    cla_pipe_addsub #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .ci(ci), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .s(s), .co(co),
        .ovf(ovf), .zero(zero)
    );

    cla_pipe_addsub #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
        .ci(ci4), .sub(sub4), .out_valid(out_valid4), .out_ready(out_ready4), .s(s4),
        .co(co4), .ovf(ovf4), .zero(zero4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model16(input logic [15:0] ta, input logic [15:0] tb,
                                     input logic tci, input logic tsub);
        exp_t e;
        int ua, ub, full, ssum;
        ua = int'(ta);
        ub = int'(tb);
        if (tsub) begin
            full = ua - ub;
            e.co = (ua >= ub);
            ssum = int'($signed(ta)) - int'($signed(tb));
        end else begin
            full = ua + ub + int'(tci);
            e.co = (full > 65535);
            ssum = int'($signed(ta)) + int'($signed(tb)) + int'(tci);
        end
        e.s    = full[15:0];
        e.ovf  = (ssum > 32767) || (ssum < -32768);
        e.zero = (e.s == 16'h0000);
        return e;
    endfunction

    function automatic logic [6:0] model4(input logic [3:0] ta, input logic [3:0] tb,
                                          input logic tci, input logic tsub);
        int ua, ub, full, ssum;
        logic [3:0] rs;
        logic rco, rovf;
        ua = int'(ta);
        ub = int'(tb);
        if (tsub) begin
            full = ua - ub;
            rco  = (ua >= ub);
            ssum = int'($signed(ta)) - int'($signed(tb));
        end else begin
            full = ua + ub + int'(tci);
            rco  = (full > 15);
            ssum = int'($signed(ta)) + int'($signed(tb)) + int'(tci);
        end
        rs   = full[3:0];
        rovf = (ssum > 7) || (ssum < -8);
        return {rs, rco, rovf, rs == 4'h0};
    endfunction

    // Compare process: sampled on the falling edge, away from the active edge.
    exp_t prev;
    bit   prev_hold = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            chk("in_ready_in_reset", {31'b0, in_ready}, 32'd0);
            q.delete();
            prev_hold = 0;
        end else begin
            chk("in_ready", {31'b0, in_ready}, {31'b0, (!out_valid || out_ready)});
            if (!in_ready) saw_stall = 1;
            if (prev_hold) begin
                chk("hold_valid", {31'b0, out_valid}, 32'd1);
                chk("hold_result", {13'b0, s, co, ovf, zero}, {13'b0, prev});
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", {16'b0, s}, 32'hDEAD_BEEF);
                end else begin
                    e = q.pop_front();
                    chk("result", {13'b0, s, co, ovf, zero}, {13'b0, e});
                    emitted++;
                end
            end
            if (in_valid && in_ready) q.push_back(model16(a, b, ci, sub));
            prev_hold = out_valid && !out_ready;
            prev = '{s: s, co: co, ovf: ovf, zero: zero};
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic tci,
                        input logic tsub);
        bit ok;
        ok = 0;
        in_valid = 1'b1;
        a = ta;
        b = tb;
        ci = tci;
        sub = tsub;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic directed(input string name, input logic [15:0] ta, input logic [15:0] tb,
                            input logic tci, input logic tsub, input logic [15:0] es,
                            input logic eco, input logic eovf, input logic ez);
        int lat;
        bit got;
        out_ready = 1'b1;
        send(ta, tb, tci, tsub);
        lat = 1;
        got = 0;
        while (!got && lat < 20) begin
            @(negedge clk);
            if (out_valid) got = 1;
            else begin
                @(posedge clk);
                #1;
                lat++;
            end
        end
        chk({name, "_latency"}, lat, 32'd4);
        chk({name, "_s"}, {16'b0, s}, {16'b0, es});
        chk({name, "_co"}, {31'b0, co}, {31'b0, eco});
        chk({name, "_ovf"}, {31'b0, ovf}, {31'b0, eovf});
        chk({name, "_zero"}, {31'b0, zero}, {31'b0, ez});
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && q.size() != 0; n++) @(posedge clk);
        #1;
        chk("drain_empty", q.size(), 32'd0);
    endtask

    initial begin
        int em0;
        bit rnd_done;
        logic [6:0] e4;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_s_flags", {13'b0, s, co, ovf, zero}, 32'd0);
        chk("reset_out_valid4", {31'b0, out_valid4}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed vectors with literal expectations
        directed("add_1_1", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
        directed("wrap", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        directed("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        directed("ovf_neg", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        directed("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        directed("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);

        // Back-to-back stream with a 6-cycle output stall
        saw_stall = 0;
        em0 = emitted;
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (6) @(posedge clk);
                #1;
                out_ready = 1'b1;
                repeat (4) begin
                    @(negedge clk);
                    chk("stream_no_gap", {31'b0, out_valid}, 32'd1);
                end
            end
        join
        drain();
        chk("stream_stalled", {31'b0, saw_stall}, 32'd1);
        chk("stream_count", emitted - em0, 32'd8);

        // Reset with three beats in flight
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) send(16'h1000 + 16'(i), 16'h0001, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_s_flags", {13'b0, s, co, ovf, zero}, 32'd0);
        em0 = emitted;
        repeat (8) @(posedge clk);
        #1;
        chk("flush_no_ghosts", emitted - em0, 32'd0);
        directed("after_reset", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);

        // Randomized traffic with random backpressure
        rnd_done = 0;
        em0 = emitted;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        chk("random_count", emitted - em0, 32'd300);

        // WIDTH=4 instance: single-cycle latency
        @(posedge clk);
        #1;
        in_valid4 = 1'b1;
        a4 = 4'b1011;
        b4 = 4'b1010;
        ci4 = 1'b1;
        sub4 = 1'b0;
        @(negedge clk);
        chk("w4_in_ready", {31'b0, in_ready4}, 32'd1);
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        @(negedge clk);
        chk("w4_out_valid", {31'b0, out_valid4}, 32'd1);
        chk("w4_result", {25'b0, s4, co4, ovf4, zero4}, {25'b0, 4'b0110, 1'b1, 1'b1, 1'b0});
        @(posedge clk);
        #1;
        for (int i = 0; i < 13; i++) begin
            if (i < 12) begin
                in_valid4 = 1'b1;
                a4 = 4'($urandom);
                b4 = 4'($urandom);
                ci4 = 1'($urandom);
                sub4 = 1'($urandom);
            end else begin
                in_valid4 = 1'b0;
            end
            @(negedge clk);
            if (i > 0) begin
                chk("w4_rand_valid", {31'b0, out_valid4}, 32'd1);
                chk("w4_rand_result", {25'b0, s4, co4, ovf4, zero4}, {25'b0, e4});
            end
            e4 = model4(a4, b4, ci4, sub4);
            @(posedge clk);
            #1;
        end

        chk("final_queue_empty", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
